exibe_sequencia: RTL and testbench

- Presentation engine for the memory game. It plays back the stored sequence to the player before the player has to repeat it.
- Reads the sequence memory from address 0 up to a given limit. Each entry drives the LEDs for T_ON cycles, followed by a T_OFF-cycle blank gap.
- On completion it pulses `pronto`, so the main control unit can enter its wait-for-move phase.
- This is the output counterpart of the play/compare control unit; it shares the same sequence memory read port (muxed at top level).

---
 rtl/jogo_pkg.sv | 28 ++
 rtl/exibe_temporizador.sv | 44 ++++
 rtl/exibe_sequencia.sv | 154 +++++++++++++++
 tb/tb_exibe_sequencia.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game: default bus widths used by the
// sequence memory and both control units, plus the presentation FSM state
// encodings and their debug codes.
package jogo_pkg;

  localparam int ADDR_W_PADRAO = 4;
  localparam int DATA_W_PADRAO = 4;

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    CARREGA = 4'h1,
    ACENDE  = 4'h2,
    APAGA   = 4'h3,
    AVANCA  = 4'h4,
    FIM     = 4'hF
  } estado_t;

  // Shown on db_estado when the state register holds an unused encoding.
  localparam logic [3:0] DB_INVALIDO = 4'hE;

  function automatic logic [3:0] codigo_debug(input estado_t e);
    case (e)
      OCIOSO, CARREGA, ACENDE, APAGA, AVANCA, FIM: return 4'(e);
      default:                                     return DB_INVALIDO;
    endcase
  endfunction

endpackage

// File: rtl/exibe_temporizador.sv
// Modulo-M cycle counter. zera has priority over conta; the count wraps to
// zero after M-1 so a back-to-back period needs no explicit clear.
module exibe_temporizador #(
  parameter int M = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] TERMINAL = W'(M - 1);

  logic [W-1:0] contagem_q;
  logic [W-1:0] contagem_d;

  // Next count: clear, advance with wrap, or hold.
  always_comb begin
    contagem_d = contagem_q;
    if (zera) begin
      contagem_d = '0;
    end else if (conta) begin
      if (contagem_q == TERMINAL) begin
        contagem_d = '0;
      end else begin
        contagem_d = contagem_q + W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem_q <= '0;
    end else begin
      contagem_q <= contagem_d;
    end
  end

  assign fim = (contagem_q == TERMINAL);

endmodule

// File: rtl/exibe_sequencia.sv
// Presentation engine: plays back sequence memory entries 0..limite on the
// LEDs, each lit for T_ON cycles followed by a T_OFF-cycle blank gap, then
// pulses pronto for one cycle.
// Optional feature macro: EXIBE_PAUSA_EN adds a pausa input that freezes the
// timers and state while in ACENDE or APAGA.
module exibe_sequencia
  import jogo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_PADRAO,
  parameter int DATA_W = DATA_W_PADRAO,
  parameter int T_ON   = 1000,
  parameter int T_OFF  = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] mem_dado,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
`ifdef EXIBE_PAUSA_EN
  ,
  input  logic              pausa
`endif
);

  estado_t             estado_q,   estado_d;
  logic [ADDR_W-1:0]   endereco_q, endereco_d;
  logic [DATA_W-1:0]   leds_q,     leds_d;
  logic [ADDR_W-1:0]   limite_q,   limite_d;

  logic pausa_i;
  logic conta_aceso, zera_aceso, fim_aceso;
  logic conta_apagado, zera_apagado, fim_apagado;

`ifdef EXIBE_PAUSA_EN
  assign pausa_i = pausa;
`else
  assign pausa_i = 1'b0;
`endif

  // Each timer runs only in its own state and is held at zero elsewhere, so
  // every ACENDE/APAGA period starts from a clean count.
  assign conta_aceso   = (estado_q == ACENDE) && !pausa_i;
  assign zera_aceso    = (estado_q != ACENDE);
  assign conta_apagado = (estado_q == APAGA) && !pausa_i;
  assign zera_apagado  = (estado_q != APAGA);

  exibe_temporizador #(
    .M (T_ON)
  ) u_tempo_aceso (
    .clock (clock),
    .reset (reset),
    .zera  (zera_aceso),
    .conta (conta_aceso),
    .fim   (fim_aceso)
  );

  exibe_temporizador #(
    .M (T_OFF)
  ) u_tempo_apagado (
    .clock (clock),
    .reset (reset),
    .zera  (zera_apagado),
    .conta (conta_apagado),
    .fim   (fim_apagado)
  );

  // Next state and next datapath values; everything holds unless a state
  // says otherwise.
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    leds_d     = leds_q;
    limite_d   = limite_q;

    case (estado_q)
      OCIOSO: begin
        leds_d     = '0;
        endereco_d = '0;
        if (iniciar) begin
          limite_d = limite;
          estado_d = CARREGA;
        end
      end

      CARREGA: begin
        leds_d   = mem_dado;
        estado_d = ACENDE;
      end

      ACENDE: begin
        if (!pausa_i && fim_aceso) begin
          leds_d   = '0;
          estado_d = APAGA;
        end
      end

      APAGA: begin
        leds_d = '0;
        if (!pausa_i && fim_apagado) begin
          // Stop on the last entry so the address never wraps mid-show.
          if (endereco_q == limite_q) begin
            estado_d = FIM;
          end else begin
            estado_d = AVANCA;
          end
        end
      end

      AVANCA: begin
        endereco_d = endereco_q + ADDR_W'(1);
        estado_d   = CARREGA;
      end

      FIM: begin
        endereco_d = '0;
        estado_d   = OCIOSO;
      end

      default: begin
        leds_d     = '0;
        endereco_d = '0;
        estado_d   = OCIOSO;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      leds_q     <= '0;
      limite_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      leds_q     <= leds_d;
      limite_q   <= limite_d;
    end
  end

  assign mem_endereco = endereco_q;
  assign leds         = leds_q;
  assign exibindo     = (estado_q == CARREGA) || (estado_q == ACENDE) ||
                        (estado_q == APAGA)   || (estado_q == AVANCA);
  assign pronto       = (estado_q == FIM);
  assign db_estado    = codigo_debug(estado_q);

endmodule

// File: tb/tb_exibe_sequencia.sv
// Bench for exibe_sequencia with T_ON=4, T_OFF=2. Expected per-cycle output
// traces are built from the show rules (per entry: one load cycle, T_ON lit
// cycles, T_OFF dark cycles, one advance cycle between entries, then one
// completion cycle) and compared cycle by cycle.
module tb_exibe_sequencia;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [3:0] db_estado;
`ifdef EXIBE_PAUSA_EN
  logic       pausa;
`endif

  logic [3:0]  mem [16];
  logic [13:0] trace [$];
  int          n_vetores = 0;
  int          n_erros   = 0;

  assign mem_dado = mem[mem_endereco];

  always #5 clock = ~clock;

  exibe_sequencia #(
    .ADDR_W (4),
    .DATA_W (4),
    .T_ON   (T_ON),
    .T_OFF  (T_OFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .limite       (limite),
    .mem_dado     (mem_dado),
    .mem_endereco (mem_endereco),
    .leds         (leds),
    .exibindo     (exibindo),
    .pronto       (pronto),
    .db_estado    (db_estado)
`ifdef EXIBE_PAUSA_EN
    ,
    .pausa        (pausa)
`endif
  );

  task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vetores++;
    if (obs !== esp) begin
      n_erros++;
      $display("FAIL %s: observado %h esperado %h", tag, obs, esp);
    end
  endtask

  function automatic logic [13:0] passo(input logic [3:0] db, input logic [3:0] lds,
                                        input logic [3:0] adr, input logic ex, input logic pr);
    return {db, lds, adr, ex, pr};
  endfunction

  function automatic logic [13:0] amostra();
    return {db_estado, leds, mem_endereco, exibindo, pronto};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected cycle-by-cycle outputs after the edge that accepts the start.
  task automatic monta(input int lim);
    trace.delete();
    for (int i = 0; i <= lim; i++) begin
      trace.push_back(passo(4'h1, 4'h0, 4'(i), 1'b1, 1'b0));
      for (int t = 0; t < T_ON; t++)
        trace.push_back(passo(4'h2, mem[i], 4'(i), 1'b1, 1'b0));
      for (int t = 0; t < T_OFF; t++)
        trace.push_back(passo(4'h3, 4'h0, 4'(i), 1'b1, 1'b0));
      if (i < lim)
        trace.push_back(passo(4'h4, 4'h0, 4'(i), 1'b1, 1'b0));
    end
    trace.push_back(passo(4'hF, 4'h0, 4'(lim), 1'b0, 1'b1));
    trace.push_back(passo(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
  endtask

  // Runs one show and compares every cycle. With perturba set, iniciar and
  // limite are randomised mid-show (they must be ignored) and, if the pause
  // feature exists, pausa is randomised: a pause in ACENDE/APAGA repeats that
  // cycle's expected outputs. encadear holds iniciar high in the closing
  // OCIOSO cycle so the next show starts immediately.
  task automatic run_show(input int lim, input bit ja_iniciado, input bit perturba,
                          input bit encadear, input int prox_lim, input int aborta_em);
    int k = 0;
    int c = 0;
    int pausas = 0;
    int visto = -1;
    int npronto = 0;
    int n = lim + 1;
    bit p;
    logic [13:0] obs;
    logic [13:0] esp;
    logic [3:0]  cod;
    monta(lim);
    if (!ja_iniciado) begin
      limite  = 4'(lim);
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
    end
    while (k < trace.size()) begin
      esp = trace[k];
      cod = esp[13:10];
      obs = amostra();
      checa($sformatf("lim%0d_ciclo%0d", lim, c), 32'(obs), 32'(esp));
      if (obs[0] === 1'b1) begin
        if (visto < 0) visto = c;
        npronto++;
      end
      if (k == aborta_em) begin
`ifdef EXIBE_PAUSA_EN
        pausa = 1'b0;
`endif
        return;
      end
      p = 1'b0;
`ifdef EXIBE_PAUSA_EN
      p = perturba && (pausas < 20) && ($urandom_range(3) == 0);
`endif
      if (perturba) begin
        iniciar = 1'($urandom);
        limite  = 4'($urandom);
      end
      if (k == trace.size() - 1) begin
        iniciar = encadear;
        limite  = 4'(prox_lim);
        p       = 1'b0;
      end
`ifdef EXIBE_PAUSA_EN
      pausa = p;
`endif
      tick();
      c++;
      if (p && (cod == 4'h2 || cod == 4'h3)) pausas++;
      else k++;
    end
`ifdef EXIBE_PAUSA_EN
    pausa = 1'b0;
`endif
    checa($sformatf("latencia_lim%0d", lim), 32'(visto),
          32'(n * (1 + T_ON + T_OFF) + (n - 1) + pausas));
    checa($sformatf("pulsos_pronto_lim%0d", lim), 32'(npronto), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observado timeout esperado fim");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    iniciar = 1'b0;
    limite  = 4'h0;
`ifdef EXIBE_PAUSA_EN
    pausa   = 1'b0;
`endif
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;

    repeat (3) tick();
    checa("em_reset", 32'(amostra()), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checa($sformatf("ocioso_%0d", i), 32'(amostra()), 32'd0);
      tick();
    end

    // Single entry.
    mem[0] = 4'b0010;
    run_show(0, 1'b0, 1'b0, 1'b0, 0, -1);

    // Three entries, plain then with ignored iniciar/limite activity.
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    run_show(2, 1'b0, 1'b0, 1'b0, 0, -1);
    run_show(2, 1'b0, 1'b1, 1'b0, 0, -1);

    // All sixteen entries, including zero words.
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
    mem[5] = 4'h0;
    run_show(15, 1'b0, 1'b0, 1'b0, 0, -1);

    // Reset during the gap of entry 1 (trace index 13), asynchronously.
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    run_show(2, 1'b0, 1'b0, 1'b0, 0, 13);
    #2;
    reset = 1'b1;
    #1;
    checa("reset_assincrono", 32'(amostra()), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checa($sformatf("pos_reset_%0d", i), 32'(amostra()), 32'd0);
      tick();
    end
    run_show(2, 1'b0, 1'b0, 1'b0, 0, -1);

    // Back-to-back shows with iniciar held through FIM.
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
    run_show(1, 1'b0, 1'b1, 1'b1, 3, -1);
    run_show(3, 1'b1, 1'b1, 1'b0, 0, -1);

    // Randomised shows.
    for (int s = 0; s < 15; s++) begin
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom);
      run_show(int'($urandom_range(15)), 1'b0, 1'b1, 1'b0, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
    $finish;
  end

endmodule
